// File: rtl/apb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : apb_pkg
// Brief    : Shared state encoding, response codes and clog2 helper for APB slaves
// Revision : 1.0
// ----------------------------------------------------------------------------
package apb_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WAIT  = 2'd1;
   localparam logic [1:0] READY = 2'd2;

   localparam logic RESP_OKAY  = 1'b0;
   localparam logic RESP_ERROR = 1'b1;

   // Loop stops at 2**30 so the shifted probe never goes negative.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/apb_mem_slave_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : apb_mem_slave_if
// Brief    : APB bus bundle between a master and the memory slave
// Revision : 1.0
// ----------------------------------------------------------------------------
interface apb_mem_slave_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic                    i_PSEL;
   logic                    i_PENABLE;
   logic                    i_PWRITE;
   logic [ADDR_WIDTH-1:0]   i_PADDR;
   logic [DATA_WIDTH-1:0]   i_PWDATA;
   logic [DATA_WIDTH/8-1:0] i_PSTRB;
   logic [DATA_WIDTH-1:0]   o_PRDATA;
   logic                    o_PREADY;
   logic                    o_PSLVERR;

   modport master (
      output i_PSEL, i_PENABLE, i_PWRITE, i_PADDR, i_PWDATA, i_PSTRB,
      input  o_PRDATA, o_PREADY, o_PSLVERR
   );

   modport slave (
      input  i_PSEL, i_PENABLE, i_PWRITE, i_PADDR, i_PWDATA, i_PSTRB,
      output o_PRDATA, o_PREADY, o_PSLVERR
   );
endinterface
`default_nettype wire

// File: rtl/apb_wait_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : apb_wait_ctrl
// Brief    : APB transfer FSM with programmable wait-state counter
// Revision : 1.0
// ----------------------------------------------------------------------------
module apb_wait_ctrl
   import apb_pkg::*;
#(
   parameter int WAIT_STATES = 0
) (
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       i_psel,
   input  wire logic       i_penable,
   output logic [1:0]      o_state,
   output logic [1:0]      o_next_state,
   output logic            o_capture
);
   localparam int c_cnt_w = (clog2(WAIT_STATES + 1) > 1) ? clog2(WAIT_STATES + 1) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(WAIT_STATES);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   logic [1:0]         r_state;
   logic [1:0]         w_next;
   logic [c_cnt_w-1:0] r_cnt;
   logic [c_cnt_w-1:0] w_cnt_next;
   logic               w_capture;

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_capture  = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_psel && !i_penable) begin
               w_capture = 1'b1;
               if (WAIT_STATES == 0) begin
                  w_next = READY;
               end else begin
                  w_next     = WAIT;
                  w_cnt_next = c_cnt_load;
               end
            end
         end
         WAIT: begin
            // Counter holds at 1 on the way to READY so it never wraps.
            if (!i_psel)                 w_next = IDLE;
            else if (r_cnt <= c_cnt_one) w_next = READY;
            else                         w_cnt_next = r_cnt - c_cnt_one;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end

   assign o_state      = r_state;
   assign o_next_state = w_next;
   assign o_capture    = w_capture;

endmodule
`default_nettype wire

// File: rtl/apb_mem_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : apb_mem_slave
// Brief    : APB memory slave; define APB_MEM_PSTRB_EN for byte-strobe writes
// Revision : 1.0
// ----------------------------------------------------------------------------
module apb_mem_slave
   import apb_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 8,
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 0
) (
   input  wire logic        i_PCLK,
   input  wire logic        i_PRESET,
   apb_mem_slave_if.slave   bus
);
   localparam int c_off_w  = clog2(DATA_WIDTH / 8);
   localparam int c_idx_w  = ADDR_WIDTH - c_off_w;
   localparam int c_mem_aw = (clog2(DEPTH) > 1) ? clog2(DEPTH) : 1;

   logic [1:0]              w_state;
   logic [1:0]              w_next_state;
   logic                    w_capture;
   logic [c_idx_w-1:0]      r_idx;
   logic [c_idx_w-1:0]      w_idx;
   logic                    r_write;
   logic                    w_write;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
   logic [c_mem_aw-1:0]     w_mem_idx;
   logic                    w_in_range;
   logic                    w_enter_ready;
   logic                    w_commit;
   logic                    r_pready;
   logic                    r_pslverr;
   logic [DATA_WIDTH-1:0]   r_prdata;
   logic                    w_unused;
`ifdef APB_MEM_PSTRB_EN
   logic [DATA_WIDTH/8-1:0] r_strb;
`endif

   apb_wait_ctrl #(.WAIT_STATES(WAIT_STATES)) u_ctrl (
      .clk          (i_PCLK),
      .rst          (i_PRESET),
      .i_psel       (bus.i_PSEL),
      .i_penable    (bus.i_PENABLE),
      .o_state      (w_state),
      .o_next_state (w_next_state),
      .o_capture    (w_capture)
   );

   // Zero-wait reads enter READY straight from setup, so decode the live bus then.
   assign w_idx         = w_capture ? bus.i_PADDR[ADDR_WIDTH-1:c_off_w] : r_idx;
   assign w_write       = w_capture ? bus.i_PWRITE : r_write;
   assign w_in_range    = (32'(w_idx) < DEPTH);
   assign w_mem_idx     = c_mem_aw'(w_idx);
   assign w_enter_ready = (w_next_state == READY);
   assign w_commit      = (w_state == READY) && bus.i_PSEL && r_write && w_in_range;
   assign w_unused      = ^{bus.i_PADDR, bus.i_PSTRB};

   always_ff @(posedge i_PCLK) begin
      if (i_PRESET) begin
         r_idx     <= '0;
         r_write   <= 1'b0;
         r_wdata   <= '0;
         r_pready  <= 1'b0;
         r_pslverr <= RESP_OKAY;
         r_prdata  <= '0;
`ifdef APB_MEM_PSTRB_EN
         r_strb    <= '0;
`endif
      end else begin
         if (w_capture) begin
            r_idx   <= bus.i_PADDR[ADDR_WIDTH-1:c_off_w];
            r_write <= bus.i_PWRITE;
            r_wdata <= bus.i_PWDATA;
`ifdef APB_MEM_PSTRB_EN
            r_strb  <= bus.i_PSTRB;
`endif
         end
         r_pready  <= w_enter_ready;
         r_pslverr <= (w_enter_ready && !w_in_range) ? RESP_ERROR : RESP_OKAY;
         r_prdata  <= (w_enter_ready && !w_write && w_in_range) ? r_mem[w_mem_idx] : '0;
      end
   end

   always_ff @(posedge i_PCLK) begin
      if (i_PRESET) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_commit) begin
`ifdef APB_MEM_PSTRB_EN
         for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (r_strb[b]) r_mem[w_mem_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
         end
`else
         r_mem[w_mem_idx] <= r_wdata;
`endif
      end
   end

   assign bus.o_PREADY  = r_pready;
   assign bus.o_PSLVERR = r_pslverr;
   assign bus.o_PRDATA  = r_prdata;

endmodule
`default_nettype wire
